// File: rtl/mem_rd_fmt_if.sv
// Bus bundle for the memory-read/format stage: ALU-stage inputs, read
// response, global stall/flush controls and the writeback-side outputs.
// slave  = the stage itself, master = the surrounding pipeline.
interface mem_rd_fmt_if #(
    parameter int XLEN = 32
) ();
    localparam int SW = XLEN / 8;

    // Pipeline control
    logic            STALL;
    logic            FLUSH;
    logic            MEM_STALL_REQ;

    // ALU-stage side
    logic [XLEN-1:0] A_PC;
    logic [31:0]     A_INST;
    logic            A_VALID;
    logic            A_DO_JMP;
    logic [XLEN-1:0] A_NEW_PC;
    logic [4:0]      A_REG_D;
    logic [XLEN-1:0] A_REG_D_V;
    logic            A_LOAD_RDEN;
    logic [XLEN-1:0] A_LOAD_ADDR;
    logic            A_STORE_WREN;
    logic [XLEN-1:0] A_STORE_ADDR;
    logic [SW-1:0]   A_STORE_STRB;
    logic [XLEN-1:0] A_STORE_DATA;

    // Read response
    logic            DATA_RDVALID;
    logic [XLEN-1:0] DATA_RDDATA;

    // Writeback side
    logic            DO_JMP;
    logic [XLEN-1:0] NEW_PC;
    logic [XLEN-1:0] M_PC;
    logic [31:0]     M_INST;
    logic            M_VALID;
    logic [4:0]      M_REG_D;
    logic [XLEN-1:0] M_REG_D_V;
    logic            M_STORE_WREN;
    logic [XLEN-1:0] M_STORE_ADDR;
    logic [SW-1:0]   M_STORE_STRB;
    logic [XLEN-1:0] M_STORE_DATA;
    logic            M_LOAD_ERR;

    modport slave (
        input  STALL, FLUSH,
        input  A_PC, A_INST, A_VALID, A_DO_JMP, A_NEW_PC, A_REG_D, A_REG_D_V,
        input  A_LOAD_RDEN, A_LOAD_ADDR,
        input  A_STORE_WREN, A_STORE_ADDR, A_STORE_STRB, A_STORE_DATA,
        input  DATA_RDVALID, DATA_RDDATA,
        output MEM_STALL_REQ, DO_JMP, NEW_PC,
        output M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V,
        output M_STORE_WREN, M_STORE_ADDR, M_STORE_STRB, M_STORE_DATA,
        output M_LOAD_ERR
    );

    modport master (
        output STALL, FLUSH,
        output A_PC, A_INST, A_VALID, A_DO_JMP, A_NEW_PC, A_REG_D, A_REG_D_V,
        output A_LOAD_RDEN, A_LOAD_ADDR,
        output A_STORE_WREN, A_STORE_ADDR, A_STORE_STRB, A_STORE_DATA,
        output DATA_RDVALID, DATA_RDDATA,
        input  MEM_STALL_REQ, DO_JMP, NEW_PC,
        input  M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V,
        input  M_STORE_WREN, M_STORE_ADDR, M_STORE_STRB, M_STORE_DATA,
        input  M_LOAD_ERR
    );
endinterface

// File: rtl/mem_rd_fmt.sv
// Memory-read stage between ALU and writeback. Holds one outstanding load,
// formats the returned data (lane select + sign/zero extension by funct3)
// and drains a response still owed after a flush.
// Optional feature: define MEM_RD_MISALIGN_CHK_EN to flag misaligned loads
// (M_LOAD_ERR=1, M_REG_D=0 on completion); otherwise M_LOAD_ERR is tied 0.
module mem_rd_fmt #(
    parameter int XLEN = 32,
    parameter int SW   = XLEN / 8
) (
    input  logic         CLK,
    input  logic         RST,
    mem_rd_fmt_if.slave  bus
);
    localparam int LW = $clog2(SW);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_DRAIN} state_t;

    state_t          state_reg, state_next;
    logic            valid_reg, do_jmp_reg, load_err_reg;
    logic [XLEN-1:0] pc_reg, new_pc_reg, reg_d_v_reg, hold_data_reg;
    logic [31:0]     inst_reg;
    logic [4:0]      reg_d_reg;
    logic [LW-1:0]   lane_reg;
    logic            st_wren_reg;
    logic [XLEN-1:0] st_addr_reg, st_data_reg;
    logic [SW-1:0]   st_strb_reg;

    logic            mem_stall_req, advance, latch_load, drain_enter, stage_clear;
    logic            completing, misalign_a;
    logic [XLEN-1:0] fmt_data;

    // Lane select and extension of a raw read word by funct3
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] d,
                                            input logic [2:0]      f3,
                                            input logic [LW-1:0]   lane);
        logic [LW-1:0]   lane_h, lane_w;
        logic [XLEN-1:0] sh_b, sh_h, sh_w, r;
        lane_h = lane & {{(LW-1){1'b1}}, 1'b0};
        lane_w = lane & {{(LW-2){1'b1}}, 2'b00};
        sh_b   = d >> {lane,   3'b000};
        sh_h   = d >> {lane_h, 3'b000};
        sh_w   = d >> {lane_w, 3'b000};
        case (f3)
            3'b000:  r = XLEN'($signed(sh_b[7:0]));
            3'b100:  r = XLEN'(sh_b[7:0]);
            3'b001:  r = XLEN'($signed(sh_h[15:0]));
            3'b101:  r = XLEN'(sh_h[15:0]);
            3'b010:  r = XLEN'($signed(sh_w[31:0]));
            3'b110:  r = (XLEN == 64) ? XLEN'(sh_w[31:0]) : d;
            default: r = d;  // LD and reserved/illegal encodings pass through
        endcase
        return r;
    endfunction

    assign fmt_data      = fmt(bus.DATA_RDDATA, inst_reg[14:12], lane_reg);
    assign mem_stall_req = ((state_reg == ST_WAIT) && !bus.DATA_RDVALID) ||
                           (state_reg == ST_DRAIN);
    assign advance       = !mem_stall_req && !bus.STALL;
    assign latch_load    = !bus.FLUSH && bus.A_VALID && bus.A_LOAD_RDEN;
    // A flush that hits a waiting load kills the stage contents right away,
    // so the drained load can never reappear once the response arrives.
    assign drain_enter   = (state_reg == ST_WAIT) && !bus.DATA_RDVALID && bus.FLUSH;
    assign stage_clear   = drain_enter || (advance && bus.FLUSH);
    assign completing    = ((state_reg == ST_WAIT) && bus.DATA_RDVALID) ||
                           (state_reg == ST_HOLD);

`ifdef MEM_RD_MISALIGN_CHK_EN
    // Natural-alignment check on the incoming load address
    always_comb begin
        misalign_a = 1'b0;
        case (bus.A_INST[14:12])
            3'b001, 3'b101: misalign_a = bus.A_LOAD_ADDR[0];
            3'b010, 3'b110: misalign_a = |bus.A_LOAD_ADDR[1:0];
            3'b011:         misalign_a = |bus.A_LOAD_ADDR[2:0];
            default:        misalign_a = 1'b0;
        endcase
    end
    assign bus.M_LOAD_ERR = completing && load_err_reg;
    assign bus.M_REG_D    = (completing && load_err_reg) ? 5'd0 : reg_d_reg;
`else
    assign misalign_a     = 1'b0;
    assign bus.M_LOAD_ERR = 1'b0;
    assign bus.M_REG_D    = reg_d_reg;
`endif

    // Load-tracking state register
    always_ff @(posedge CLK) begin
        if (RST) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic for the outstanding-load tracker
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (advance && latch_load) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.DATA_RDVALID) begin
                    if (bus.STALL)       state_next = ST_HOLD;
                    else if (latch_load) state_next = ST_WAIT;
                    else                 state_next = ST_IDLE;
                end else if (bus.FLUSH) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (!bus.STALL) state_next = latch_load ? ST_WAIT : ST_IDLE;
            end
            ST_DRAIN: if (bus.DATA_RDVALID) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Stage register: reset/flush clears, stall holds, otherwise latch A_*
    always_ff @(posedge CLK) begin
        if (RST || stage_clear) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            inst_reg     <= '0;
            do_jmp_reg   <= 1'b0;
            new_pc_reg   <= '0;
            reg_d_reg    <= '0;
            reg_d_v_reg  <= '0;
            lane_reg     <= '0;
            load_err_reg <= 1'b0;
            st_wren_reg  <= 1'b0;
            st_addr_reg  <= '0;
            st_strb_reg  <= '0;
            st_data_reg  <= '0;
        end else if (advance) begin
            valid_reg    <= bus.A_VALID;
            pc_reg       <= bus.A_PC;
            inst_reg     <= bus.A_INST;
            do_jmp_reg   <= bus.A_DO_JMP;
            new_pc_reg   <= bus.A_NEW_PC;
            reg_d_reg    <= bus.A_REG_D;
            reg_d_v_reg  <= bus.A_REG_D_V;
            lane_reg     <= bus.A_LOAD_ADDR[LW-1:0];
            load_err_reg <= bus.A_VALID && bus.A_LOAD_RDEN && misalign_a;
            st_wren_reg  <= bus.A_STORE_WREN;
            st_addr_reg  <= bus.A_STORE_ADDR;
            st_strb_reg  <= bus.A_STORE_STRB;
            st_data_reg  <= bus.A_STORE_DATA;
        end
    end

    // Capture formatted read data when the response lands during a stall
    always_ff @(posedge CLK) begin
        if (RST)
            hold_data_reg <= '0;
        else if ((state_reg == ST_WAIT) && bus.DATA_RDVALID && bus.STALL)
            hold_data_reg <= fmt_data;
    end

    // Writeback result value: live response, held capture, or ALU result
    always_comb begin
        bus.M_REG_D_V = reg_d_v_reg;
        if ((state_reg == ST_WAIT) && bus.DATA_RDVALID) bus.M_REG_D_V = fmt_data;
        else if (state_reg == ST_HOLD)                  bus.M_REG_D_V = hold_data_reg;
    end

    assign bus.MEM_STALL_REQ = mem_stall_req;
    assign bus.M_VALID       = valid_reg && !mem_stall_req;
    assign bus.M_PC          = pc_reg;
    assign bus.M_INST        = inst_reg;
    assign bus.DO_JMP        = do_jmp_reg;
    assign bus.NEW_PC        = new_pc_reg;
    assign bus.M_STORE_WREN  = st_wren_reg;
    assign bus.M_STORE_ADDR  = st_addr_reg;
    assign bus.M_STORE_STRB  = st_strb_reg;
    assign bus.M_STORE_DATA  = st_data_reg;
endmodule

// File: tb/tb_mem_rd_fmt.sv
// Directed testbench for mem_rd_fmt (XLEN=32): ALU pass-through, delayed
// loads, hold under stall, flush/drain, reset mid-load, back-to-back loads
// and the optional misaligned-load flag.
module tb_mem_rd_fmt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_rd_fmt_if #(.XLEN(32)) bus ();

    mem_rd_fmt #(.XLEN(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        bus.A_PC = '0; bus.A_INST = '0; bus.A_VALID = 1'b0; bus.A_DO_JMP = 1'b0;
        bus.A_NEW_PC = '0; bus.A_REG_D = '0; bus.A_REG_D_V = '0;
        bus.A_LOAD_RDEN = 1'b0; bus.A_LOAD_ADDR = '0;
        bus.A_STORE_WREN = 1'b0; bus.A_STORE_ADDR = '0; bus.A_STORE_STRB = '0;
        bus.A_STORE_DATA = '0;
    endtask

    task automatic drive_load(input logic [31:0] inst, input logic [31:0] addr,
                              input logic [4:0] rd, input logic [31:0] pc);
        clear_a();
        bus.A_VALID = 1'b1; bus.A_LOAD_RDEN = 1'b1; bus.A_INST = inst;
        bus.A_LOAD_ADDR = addr; bus.A_REG_D = rd; bus.A_PC = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (bus.M_VALID !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", bus.M_VALID); end
        checks++; if (bus.MEM_STALL_REQ !== 1'b0) begin failures++; $display("FAIL reset_stall_req got=%0b exp=0", bus.MEM_STALL_REQ); end
        checks++; if (bus.M_REG_D_V !== 32'h0) begin failures++; $display("FAIL reset_reg_d_v got=%h exp=0", bus.M_REG_D_V); end
        checks++; if (bus.DO_JMP !== 1'b0 || bus.M_STORE_WREN !== 1'b0 || bus.M_LOAD_ERR !== 1'b0) begin
            failures++; $display("FAIL reset_flags got jmp=%0b wren=%0b err=%0b exp=0", bus.DO_JMP, bus.M_STORE_WREN, bus.M_LOAD_ERR); end
        $display("test_reset: outputs after reset v=%0b req=%0b", bus.M_VALID, bus.MEM_STALL_REQ);
    endtask

    task automatic test_alu();
        step();
        clear_a();
        bus.A_VALID = 1'b1; bus.A_PC = 32'h100; bus.A_INST = 32'h0000_0013;
        bus.A_REG_D = 5'd5; bus.A_REG_D_V = 32'h1234;
        bus.A_DO_JMP = 1'b1; bus.A_NEW_PC = 32'h200;
        bus.A_STORE_WREN = 1'b1; bus.A_STORE_ADDR = 32'h40; bus.A_STORE_STRB = 4'hF;
        bus.A_STORE_DATA = 32'hCAFE_F00D;
        step();
        clear_a();
        #1;
        checks++; if (bus.M_VALID !== 1'b1 || bus.M_REG_D !== 5'd5 || bus.M_REG_D_V !== 32'h1234) begin
            failures++; $display("FAIL alu_result got v=%0b rd=%0d val=%h exp v=1 rd=5 val=1234", bus.M_VALID, bus.M_REG_D, bus.M_REG_D_V); end
        checks++; if (bus.MEM_STALL_REQ !== 1'b0 || bus.M_PC !== 32'h100) begin
            failures++; $display("FAIL alu_pc got req=%0b pc=%h exp req=0 pc=100", bus.MEM_STALL_REQ, bus.M_PC); end
        checks++; if (bus.DO_JMP !== 1'b1 || bus.NEW_PC !== 32'h200) begin
            failures++; $display("FAIL alu_jump got jmp=%0b pc=%h exp jmp=1 pc=200", bus.DO_JMP, bus.NEW_PC); end
        checks++; if (bus.M_STORE_WREN !== 1'b1 || bus.M_STORE_ADDR !== 32'h40 || bus.M_STORE_STRB !== 4'hF || bus.M_STORE_DATA !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL alu_store got w=%0b a=%h s=%h d=%h exp 1 40 f cafef00d", bus.M_STORE_WREN, bus.M_STORE_ADDR, bus.M_STORE_STRB, bus.M_STORE_DATA); end
        step();
        checks++; if (bus.M_VALID !== 1'b0) begin failures++; $display("FAIL alu_bubble got=%0b exp=0", bus.M_VALID); end
        $display("test_alu: rd=5 val=1234 pass-through observed");
    endtask

    task automatic test_lb_delay();
        drive_load(32'h0000_0003, 32'h1003, 5'd9, 32'h300);
        step();
        clear_a();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.MEM_STALL_REQ !== 1'b1 || bus.M_VALID !== 1'b0) begin
                failures++; $display("FAIL lb_wait%0d got req=%0b v=%0b exp req=1 v=0", i, bus.MEM_STALL_REQ, bus.M_VALID); end
            step();
        end
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'h80FF_FFFF;
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b0 || bus.M_VALID !== 1'b1 || bus.M_REG_D !== 5'd9) begin
            failures++; $display("FAIL lb_done got req=%0b v=%0b rd=%0d exp req=0 v=1 rd=9", bus.MEM_STALL_REQ, bus.M_VALID, bus.M_REG_D); end
        checks++; if (bus.M_REG_D_V !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL lb_data got=%h exp=ffffff80", bus.M_REG_D_V); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        #1;
        checks++; if (bus.M_VALID !== 1'b0 || bus.MEM_STALL_REQ !== 1'b0) begin
            failures++; $display("FAIL lb_idle got v=%0b req=%0b exp 0 0", bus.M_VALID, bus.MEM_STALL_REQ); end
        $display("test_lb_delay: LB lane3 after 3 wait cycles -> %h", 32'hFFFF_FF80);
    endtask

    task automatic test_lhu_hold();
        drive_load(32'h0000_5003, 32'h2002, 5'd10, 32'h400);
        step();
        clear_a();
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'hBEEF_0000; bus.STALL = 1'b1;
        #1;
        checks++; if (bus.M_VALID !== 1'b1 || bus.M_REG_D_V !== 32'h0000_BEEF) begin
            failures++; $display("FAIL lhu_resp got v=%0b val=%h exp v=1 val=0000beef", bus.M_VALID, bus.M_REG_D_V); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.M_VALID !== 1'b1 || bus.M_REG_D_V !== 32'h0000_BEEF || bus.MEM_STALL_REQ !== 1'b0) begin
                failures++; $display("FAIL lhu_hold%0d got v=%0b val=%h req=%0b exp 1 0000beef 0", i, bus.M_VALID, bus.M_REG_D_V, bus.MEM_STALL_REQ); end
            step();
        end
        bus.STALL = 1'b0;
        #1;
        checks++; if (bus.M_REG_D_V !== 32'h0000_BEEF || bus.M_REG_D !== 5'd10) begin
            failures++; $display("FAIL lhu_release got val=%h rd=%0d exp 0000beef 10", bus.M_REG_D_V, bus.M_REG_D); end
        step();
        bus.DATA_RDDATA = '0;
        #1;
        checks++; if (bus.M_VALID !== 1'b0) begin failures++; $display("FAIL lhu_idle got=%0b exp=0", bus.M_VALID); end
        $display("test_lhu_hold: LHU lane2 held as %h", 32'h0000_BEEF);
    endtask

    task automatic test_flush_drain();
        drive_load(32'h0000_2003, 32'h3000, 5'd11, 32'h500);
        step();
        clear_a();
        bus.FLUSH = 1'b1;
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b1) begin failures++; $display("FAIL flush_wait got=%0b exp=1", bus.MEM_STALL_REQ); end
        step();
        bus.FLUSH = 1'b0;
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b1 || bus.M_VALID !== 1'b0) begin
            failures++; $display("FAIL drain_state got req=%0b v=%0b exp 1 0", bus.MEM_STALL_REQ, bus.M_VALID); end
        step();
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.M_VALID !== 1'b0 || bus.MEM_STALL_REQ !== 1'b1) begin
            failures++; $display("FAIL drain_resp got v=%0b req=%0b exp 0 1", bus.M_VALID, bus.MEM_STALL_REQ); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b0 || bus.M_VALID !== 1'b0 || bus.M_REG_D_V !== 32'h0) begin
            failures++; $display("FAIL drain_idle got req=%0b v=%0b val=%h exp 0 0 0", bus.MEM_STALL_REQ, bus.M_VALID, bus.M_REG_D_V); end
        $display("test_flush_drain: response deadbeef discarded");
    endtask

    task automatic test_rst_in_wait();
        drive_load(32'h0000_0003, 32'h6001, 5'd12, 32'h600);
        bus.A_DO_JMP = 1'b1; bus.A_NEW_PC = 32'h700;
        step();
        clear_a();
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0b exp=1", bus.MEM_STALL_REQ); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.M_VALID !== 1'b0 || bus.MEM_STALL_REQ !== 1'b0 || bus.M_REG_D_V !== 32'h0 ||
                      bus.M_REG_D !== 5'd0 || bus.M_PC !== 32'h0 || bus.DO_JMP !== 1'b0 || bus.NEW_PC !== 32'h0) begin
            failures++; $display("FAIL rst_outputs got v=%0b req=%0b val=%h rd=%0d pc=%h jmp=%0b exp all 0",
                                 bus.M_VALID, bus.MEM_STALL_REQ, bus.M_REG_D_V, bus.M_REG_D, bus.M_PC, bus.DO_JMP); end
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'h0000_0055;
        #1;
        checks++; if (bus.M_VALID !== 1'b0 || bus.MEM_STALL_REQ !== 1'b0 || bus.M_REG_D_V !== 32'h0) begin
            failures++; $display("FAIL rst_late_resp got v=%0b req=%0b val=%h exp 0 0 0", bus.M_VALID, bus.MEM_STALL_REQ, bus.M_REG_D_V); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        $display("test_rst_in_wait: reset mid-load returns to idle");
    endtask

    task automatic test_back_to_back();
        drive_load(32'h0000_0003, 32'h0010, 5'd1, 32'h800);
        step();
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'h0000_007F;
        drive_load(32'h0000_4003, 32'h0011, 5'd2, 32'h804);
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b0 || bus.M_VALID !== 1'b1 || bus.M_REG_D_V !== 32'h7F || bus.M_REG_D !== 5'd1) begin
            failures++; $display("FAIL b2b_first got req=%0b v=%0b val=%h rd=%0d exp 0 1 7f 1", bus.MEM_STALL_REQ, bus.M_VALID, bus.M_REG_D_V, bus.M_REG_D); end
        step();
        clear_a();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        #1;
        checks++; if (bus.MEM_STALL_REQ !== 1'b1 || bus.M_VALID !== 1'b0) begin
            failures++; $display("FAIL b2b_wait got req=%0b v=%0b exp 1 0", bus.MEM_STALL_REQ, bus.M_VALID); end
        step();
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'h0000_8000;
        #1;
        checks++; if (bus.M_VALID !== 1'b1 || bus.M_REG_D_V !== 32'h0000_0080 || bus.M_REG_D !== 5'd2 || bus.M_PC !== 32'h804) begin
            failures++; $display("FAIL b2b_second got v=%0b val=%h rd=%0d pc=%h exp 1 00000080 2 804", bus.M_VALID, bus.M_REG_D_V, bus.M_REG_D, bus.M_PC); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        // LH lane2 sign-extension, response in first wait cycle
        drive_load(32'h0000_1003, 32'h0022, 5'd3, 32'h808);
        step();
        clear_a();
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'h8001_1234;
        #1;
        checks++; if (bus.M_VALID !== 1'b1 || bus.M_REG_D_V !== 32'hFFFF_8001) begin
            failures++; $display("FAIL lh_sign got v=%0b val=%h exp 1 ffff8001", bus.M_VALID, bus.M_REG_D_V); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        $display("test_back_to_back: LB 7f, LBU 80, LH ffff8001");
    endtask

    task automatic test_misalign();
        logic       exp_err;
        logic [4:0] exp_rd;
`ifdef MEM_RD_MISALIGN_CHK_EN
        exp_err = 1'b1; exp_rd = 5'd0;
`else
        exp_err = 1'b0; exp_rd = 5'd7;
`endif
        drive_load(32'h0000_2003, 32'h4002, 5'd7, 32'h900);
        step();
        clear_a();
        bus.DATA_RDVALID = 1'b1; bus.DATA_RDDATA = 32'h1122_3344;
        #1;
        checks++; if (bus.M_LOAD_ERR !== exp_err || bus.M_REG_D !== exp_rd || bus.M_VALID !== 1'b1) begin
            failures++; $display("FAIL misalign_flag got err=%0b rd=%0d v=%0b exp err=%0b rd=%0d v=1", bus.M_LOAD_ERR, bus.M_REG_D, bus.M_VALID, exp_err, exp_rd); end
        checks++; if (bus.M_REG_D_V !== 32'h1122_3344) begin
            failures++; $display("FAIL misalign_data got=%h exp=11223344", bus.M_REG_D_V); end
        step();
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        #1;
        checks++; if (bus.M_LOAD_ERR !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%0b exp=0", bus.M_LOAD_ERR); end
        $display("test_misalign: LW addr low=2 err=%0b", exp_err);
    endtask

    initial begin
        clear_a();
        bus.STALL = 1'b0; bus.FLUSH = 1'b0;
        bus.DATA_RDVALID = 1'b0; bus.DATA_RDDATA = '0;
        test_reset();
        test_alu();
        test_lb_delay();
        test_lhu_hold();
        test_flush_drain();
        test_rst_in_wait();
        test_back_to_back();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
